decode_stage: RTL

Registered, multi-slot MIPS32 decode stage. Takes a fetch bundle of up to `DECODE_WIDTH` instructions and decodes SPECIAL, REGIMM, I-type and J-type formats. Produces a left-aligned bundle of decoded slots held in an output register. Sits between the fetch queue and rename/issue, and supports in-order partial acceptance by the downstream stage and a flush.

---
 rtl/decode_stage_pkg.sv | 48 ++++
 rtl/inst_decoder_slot.sv | 85 ++++++++
 rtl/decode_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared MIPS32 decode types: operation enum, opcode/funct/REGIMM-rt codes, per-slot decoded struct.
// Trap operations stay in the enum whether or not DECODE_TRAP_EN is defined.
package decode_stage_pkg;

    typedef enum logic [6:0] {
        OP_INVALID,
        OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_JR, OP_JALR,
        OP_MOVZ, OP_MOVN, OP_SYSCALL, OP_BREAK, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
        OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_TGE, OP_TGEU, OP_TLT, OP_TLTU, OP_TEQ, OP_TNE,
        OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL,
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_J, OP_JAL
    } operation_t;

    localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_REGIMM = 6'h01, OPC_J = 6'h02, OPC_JAL = 6'h03,
        OPC_BEQ = 6'h04, OPC_BNE = 6'h05, OPC_BLEZ = 6'h06, OPC_BGTZ = 6'h07,
        OPC_ADDI = 6'h08, OPC_ADDIU = 6'h09, OPC_SLTI = 6'h0A, OPC_SLTIU = 6'h0B,
        OPC_ANDI = 6'h0C, OPC_ORI = 6'h0D, OPC_XORI = 6'h0E, OPC_LUI = 6'h0F,
        OPC_LB = 6'h20, OPC_LH = 6'h21, OPC_LW = 6'h23, OPC_LBU = 6'h24, OPC_LHU = 6'h25,
        OPC_SB = 6'h28, OPC_SH = 6'h29, OPC_SW = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04,
        FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08, FN_JALR = 6'h09, FN_MOVZ = 6'h0A,
        FN_MOVN = 6'h0B, FN_SYSCALL = 6'h0C, FN_BREAK = 6'h0D, FN_MFHI = 6'h10, FN_MTHI = 6'h11,
        FN_MFLO = 6'h12, FN_MTLO = 6'h13, FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A,
        FN_DIVU = 6'h1B, FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
        FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A,
        FN_SLTU = 6'h2B, FN_TGE = 6'h30, FN_TGEU = 6'h31, FN_TLT = 6'h32, FN_TLTU = 6'h33,
        FN_TEQ = 6'h34, FN_TNE = 6'h36;

    localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

    typedef struct packed {
        operation_t  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [31:0] imm;
        logic [25:0] jidx;
        logic        ri;
    } decoded_inst_t;

endpackage

// File: rtl/inst_decoder_slot.sv
// Combinational single-slot MIPS32 decoder. Define DECODE_TRAP_EN to decode the
// conditional trap functions; otherwise they raise a reserved-instruction flag.
module inst_decoder_slot
    import decode_stage_pkg::*;
(
    input  logic          valid_i,
    input  logic [31:0]   inst_i,
    output decoded_inst_t dec_o
);
    logic [5:0]  opc;
    operation_t  op;
    logic [31:0] imm;

    assign opc = inst_i[31:26];

    always_comb begin
        op = OP_INVALID;
        case (opc)
            OPC_SPECIAL: begin
                case (inst_i[5:0])
                    FN_SLL:  op = OP_SLL;   FN_SRL:  op = OP_SRL;   FN_SRA:  op = OP_SRA;
                    FN_SLLV: op = OP_SLLV;  FN_SRLV: op = OP_SRLV;  FN_SRAV: op = OP_SRAV;
                    FN_JR:   op = OP_JR;    FN_JALR: op = OP_JALR;  FN_MOVZ: op = OP_MOVZ;
                    FN_MOVN: op = OP_MOVN;  FN_SYSCALL: op = OP_SYSCALL; FN_BREAK: op = OP_BREAK;
                    FN_MFHI: op = OP_MFHI;  FN_MTHI: op = OP_MTHI;  FN_MFLO: op = OP_MFLO;
                    FN_MTLO: op = OP_MTLO;  FN_MULT: op = OP_MULT;  FN_MULTU: op = OP_MULTU;
                    FN_DIV:  op = OP_DIV;   FN_DIVU: op = OP_DIVU;  FN_ADD:  op = OP_ADD;
                    FN_ADDU: op = OP_ADDU;  FN_SUB:  op = OP_SUB;   FN_SUBU: op = OP_SUBU;
                    FN_AND:  op = OP_AND;   FN_OR:   op = OP_OR;    FN_XOR:  op = OP_XOR;
                    FN_NOR:  op = OP_NOR;   FN_SLT:  op = OP_SLT;   FN_SLTU: op = OP_SLTU;
`ifdef DECODE_TRAP_EN
                    FN_TGE:  op = OP_TGE;   FN_TGEU: op = OP_TGEU;  FN_TLT:  op = OP_TLT;
                    FN_TLTU: op = OP_TLTU;  FN_TEQ:  op = OP_TEQ;   FN_TNE:  op = OP_TNE;
`else
                    FN_TGE, FN_TGEU, FN_TLT, FN_TLTU, FN_TEQ, FN_TNE: op = OP_INVALID;
`endif
                    default: op = OP_INVALID;
                endcase
            end
            OPC_REGIMM: begin
                case (inst_i[20:16])
                    RT_BLTZ:   op = OP_BLTZ;   RT_BGEZ:   op = OP_BGEZ;
                    RT_BLTZAL: op = OP_BLTZAL; RT_BGEZAL: op = OP_BGEZAL;
                    default:   op = OP_INVALID;
                endcase
            end
            OPC_J:     op = OP_J;     OPC_JAL:   op = OP_JAL;
            OPC_BEQ:   op = OP_BEQ;   OPC_BNE:   op = OP_BNE;   OPC_BLEZ:  op = OP_BLEZ;
            OPC_BGTZ:  op = OP_BGTZ;  OPC_ADDI:  op = OP_ADDI;  OPC_ADDIU: op = OP_ADDIU;
            OPC_SLTI:  op = OP_SLTI;  OPC_SLTIU: op = OP_SLTIU; OPC_ANDI:  op = OP_ANDI;
            OPC_ORI:   op = OP_ORI;   OPC_XORI:  op = OP_XORI;  OPC_LUI:   op = OP_LUI;
            OPC_LB:    op = OP_LB;    OPC_LH:    op = OP_LH;    OPC_LW:    op = OP_LW;
            OPC_LBU:   op = OP_LBU;   OPC_LHU:   op = OP_LHU;   OPC_SB:    op = OP_SB;
            OPC_SH:    op = OP_SH;    OPC_SW:    op = OP_SW;
            default:   op = OP_INVALID;
        endcase
    end

    always_comb begin
        case (opc)
            OPC_SPECIAL, OPC_J, OPC_JAL: imm = '0;
            OPC_ANDI, OPC_ORI, OPC_XORI: imm = {16'h0, inst_i[15:0]};
            OPC_LUI:                     imm = {inst_i[15:0], 16'h0};
            default:                     imm = {{16{inst_i[15]}}, inst_i[15:0]};
        endcase
    end

    // Empty and reserved slots carry zeroed fields so downstream never sees stale bits.
    always_comb begin
        dec_o    = '0;
        dec_o.op = OP_INVALID;
        if (valid_i && op == OP_INVALID) begin
            dec_o.ri = 1'b1;
        end else if (valid_i) begin
            dec_o.op   = op;
            dec_o.rs   = inst_i[25:21];
            dec_o.rt   = inst_i[20:16];
            dec_o.rd   = inst_i[15:11];
            dec_o.sa   = inst_i[10:6];
            dec_o.imm  = imm;
            dec_o.jidx = (op == OP_J || op == OP_JAL) ? inst_i[25:0] : '0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered multi-slot MIPS32 decode stage with in-order partial accept and flush.
// DECODE_TRAP_EN (see inst_decoder_slot) enables trap decode.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DECODE_WIDTH = 2,
    parameter int CNT_W        = $clog2(DECODE_WIDTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [DECODE_WIDTH-1:0]            in_valid,
    input  logic [DECODE_WIDTH-1:0][31:0]      in_inst,
    input  logic [DECODE_WIDTH-1:0][31:0]      in_pc,
    output logic                               in_ready,
    output logic [DECODE_WIDTH-1:0]            out_valid,
    output operation_t [DECODE_WIDTH-1:0]      out_op,
    output logic [DECODE_WIDTH-1:0][4:0]       out_rs,
    output logic [DECODE_WIDTH-1:0][4:0]       out_rt,
    output logic [DECODE_WIDTH-1:0][4:0]       out_rd,
    output logic [DECODE_WIDTH-1:0][4:0]       out_sa,
    output logic [DECODE_WIDTH-1:0][31:0]      out_imm,
    output logic [DECODE_WIDTH-1:0][25:0]      out_jidx,
    output logic [DECODE_WIDTH-1:0][31:0]      out_pc,
    output logic [DECODE_WIDTH-1:0]            out_ri,
    input  logic [CNT_W-1:0]                   out_accept
);
    decoded_inst_t [DECODE_WIDTH-1:0]       dec, slot_q, slot_d;
    logic          [DECODE_WIDTH-1:0][31:0] pc_q, pc_d;
    logic          [DECODE_WIDTH-1:0]       valid_q, valid_d;
    logic          [CNT_W-1:0]              held, acc;
    logic                                   load;

    for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_slot
        inst_decoder_slot u_dec (
            .valid_i (in_valid[g]),
            .inst_i  (in_inst[g]),
            .dec_o   (dec[g])
        );
        assign out_op[g]   = slot_q[g].op;
        assign out_rs[g]   = slot_q[g].rs;
        assign out_rt[g]   = slot_q[g].rt;
        assign out_rd[g]   = slot_q[g].rd;
        assign out_sa[g]   = slot_q[g].sa;
        assign out_imm[g]  = slot_q[g].imm;
        assign out_jidx[g] = slot_q[g].jidx;
        assign out_ri[g]   = slot_q[g].ri;
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;

    always_comb begin
        held = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) held += CNT_W'(valid_q[i]);
        acc = (out_accept > held) ? held : out_accept;
    end

    assign in_ready = (held == acc) && !flush;
    assign load     = in_ready && |in_valid;

    // Vacated slots fall back to the all-zero (OP_INVALID) entry.
    always_comb begin
        slot_d  = '0;
        pc_d    = '0;
        valid_d = '0;
        if (!flush) begin
            if (load) begin
                slot_d  = dec;
                valid_d = in_valid;
                for (int i = 0; i < DECODE_WIDTH; i++) pc_d[i] = in_valid[i] ? in_pc[i] : '0;
            end else begin
                for (int s = 0; s <= DECODE_WIDTH; s++) begin
                    if (int'(acc) == s) begin
                        for (int i = 0; i + s < DECODE_WIDTH; i++) begin
                            slot_d[i]  = slot_q[i+s];
                            pc_d[i]    = pc_q[i+s];
                            valid_d[i] = valid_q[i+s];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= '0;
            pc_q    <= '0;
            valid_q <= '0;
        end else begin
            slot_q  <= slot_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

`ifndef SYNTHESIS
    logic [DECODE_WIDTH-1:0] vld_inc;
    assign vld_inc = in_valid + DECODE_WIDTH'(1);

    always @(posedge clk) begin
        if (!rst) begin
            assert ((in_valid & vld_inc) == '0)
                else $error("decode_stage: in_valid not left-aligned: %b", in_valid);
            assert (out_accept <= held)
                else $error("decode_stage: out_accept %0d exceeds held %0d", out_accept, held);
        end
    end
`endif

endmodule
